pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Drives the per-stage stall inputs and the ID/EX flush (bubble) controls. Sources: load-use
//  hazards, taken branches, instruction-memory wait and data-memory wait.
//  Tracks a wrong-path fetch squash across imem waits, counts stall cycles, and flags dmem timeouts.
// PARAMETERS
//  CNT_WIDTH    32   width of stall_cnt performance counter
//  TIMEOUT      255  consecutive dmem-wait cycles before mem_timeout sets (>=1)
//  TO_WIDTH     8    width of dmem-wait counter; must hold TIMEOUT
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          synchronous reset, active-high
//  id_rs1       in   5          rs1 index of instruction in ID
//  id_rs2       in   5          rs2 index of instruction in ID
//  id_use_rs1   in   1          ID instruction reads rs1
//  id_use_rs2   in   1          ID instruction reads rs2
//  ex_rd        in   5          rd index of instruction in EX
//  ex_is_load   in   1          EX instruction is a load
//  ex_br_taken  in   1          EX branch/jump resolved taken (PC redirect this cycle)
//  imem_ready   in   1          instruction fetch data valid this cycle
//  dmem_req     in   1          MEM stage has an access outstanding
//  dmem_ready   in   1          data memory completes access this cycle
//  stall_if     out  1          hold PC
//  stall_id     out  1          hold IF/ID register
//  stall_ex     out  1          hold ID/EX register
//  stall_mem    out  1          hold EX/MEM register
//  stall_wb     out  1          hold MEM/WB register
//  flush_id     out  1          load NOP into IF/ID
//  flush_ex     out  1          load NOP into ID/EX
//  mem_timeout  out  1          sticky: dmem wait reached TIMEOUT
//  stall_cnt    out  CNT_WIDTH  cycles with stall_if=1, saturating
// BEHAVIOUR
//  - States RUN, SQUASH (wrong-path fetch in flight). Stall/flush outputs combinational from state + inputs.
//  - rst=1: all stall/flush outputs 0 that cycle. Next cycle: state=RUN, stall_cnt=0, wait cnt=0, mem_timeout=0.
//  - dmem_wait = dmem_req & ~dmem_ready; load_use = ex_is_load & ex_rd!=0 &
//    ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - Priority per cycle, first match wins:
//    1 dmem_wait: all five stalls=1, flushes=0; state held; br_taken ignored (EX frozen, re-presents).
//    2 ex_br_taken: flush_id=flush_ex=1, stalls=0; if imem_ready=0 -> SQUASH. load_use ignored.
//    3 load_use (RUN): stall_if=stall_id=1, flush_ex=1, others 0. Exactly one bubble per hazard.
//    4 RUN & ~imem_ready: stall_if=1, flush_id=1, others 0.
//    5 SQUASH: stall_if=1, flush_id=1. If imem_ready=1 -> RUN (stale data discarded, target refetched).
//    6 otherwise all 0.
//  - In SQUASH, load_use is evaluated as in RUN and merges: union of rule-3 and rule-5 outputs.
//  - Wait counter: +1 each dmem_wait cycle, cleared on any non-wait cycle; at ==TIMEOUT set mem_timeout (sticky till rst).
//    Counter saturates at TIMEOUT.
//  - stall_cnt: +1 each cycle stall_if=1, saturates at all-ones, never wraps.
//  - Reset mid-wait/mid-SQUASH: state, counters, mem_timeout all cleared; no pending squash survives.
// TESTING
//  1 ex_is_load=1 ex_rd=5, id_rs1=5 id_use_rs1=1 -> 1 cycle: stall_if=stall_id=flush_ex=1; then ex_is_load=0 -> all 0.
//  2 ex_rd=0 load, id_rs1=0 used -> no stall; id_use_rs2=0 with id_rs2=ex_rd=7 -> no stall.
//  3 dmem_req=1 dmem_ready=0 for 3 cycles with ex_br_taken=1 -> all stalls=1, flushes=0; then ready -> flush_id=flush_ex=1.
//  4 ex_br_taken=1 with imem_ready=0 -> SQUASH; 2 more imem_ready=0 cycles -> stall_if=flush_id=1; imem_ready=1 -> flush_id=1, then RUN.
//  5 TIMEOUT=4: 4 consecutive dmem_wait -> mem_timeout=1 on 5th cycle, stays 1 after ready; rst -> 0.
//  6 rst asserted during SQUASH with stall_cnt=10 -> next cycle state RUN, stall_cnt=0, outputs 0 with imem_ready=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
//
// Purpose:
//   Produces the per-stage hold (stall_*) and bubble (flush_*) controls for the
//   IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Hazard sources are
//   data-memory waits, taken branches, load-use dependencies and instruction
//   fetch waits. A wrong-path fetch that is still outstanding when a branch
//   redirects the PC is tracked in the SQUASH state so its data is thrown away.
//   Also keeps a saturating stall-cycle counter and a sticky dmem timeout flag.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1, id_rs2                source register indices of the ID instruction
//   id_use_rs1, id_use_rs2        ID instruction actually reads that source
//   ex_rd, ex_is_load             destination and load flag of the EX instruction
//   ex_br_taken                   EX resolved a taken branch/jump this cycle
//   imem_ready                    instruction fetch data valid this cycle
//   dmem_req, dmem_ready          MEM access outstanding / completing this cycle
//   stall_if..stall_wb            hold PC and each pipeline register
//   flush_id, flush_ex            load a NOP into IF/ID, ID/EX
//   mem_timeout                   sticky: dmem wait reached TIMEOUT cycles
//   stall_cnt                     saturating count of cycles with stall_if=1

module pipe_hazard_ctrl #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 255,
    parameter int TO_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_is_load,
    input  logic                 ex_br_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 stall_mem,
    output logic                 stall_wb,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    localparam logic [TO_WIDTH-1:0]  TO_LIMIT = TO_WIDTH'(TIMEOUT);
    localparam logic [TO_WIDTH-1:0]  TO_ONE   = TO_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [0:0]           state_q,       state_d;
    logic [TO_WIDTH-1:0]  wait_cnt_q,    wait_cnt_d;
    logic                 mem_timeout_q, mem_timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q,   stall_cnt_d;

    logic dmem_wait;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    // Hazard detection
    always_comb begin
        dmem_wait = dmem_req & ~dmem_ready;
        rs1_hit   = id_use_rs1 & (id_rs1 == ex_rd);
        rs2_hit   = id_use_rs2 & (id_rs2 == ex_rd);
        // x0 is hardwired zero, so a load targeting it never creates a dependency.
        load_use  = ex_is_load & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    end

    // Stall/flush decode and FSM next state
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        state_d   = state_q;

        if (rst) begin
            // Outputs stay quiet during reset; state is cleared in the flop block.
            state_d = ST_RUN;
        end else if (dmem_wait) begin
            // Whole pipe frozen. A taken branch in EX is simply re-presented
            // once memory completes, so it is not acted on here.
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            stall_wb  = 1'b1;
        end else if (ex_br_taken) begin
            // Redirect: kill both younger instructions. If the fetch for the
            // old path is still outstanding its data must be dropped on arrival.
            flush_id = 1'b1;
            flush_ex = 1'b1;
            state_d  = imem_ready ? ST_RUN : ST_SQUASH;
        end else begin
            if (load_use) begin
                // One bubble into EX; IF and ID replay next cycle, by which
                // time the load has moved to MEM and forwarding covers it.
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
            if (state_q == ST_SQUASH) begin
                // Wrong-path fetch in flight: whatever arrives is discarded
                // and the PC is held so the branch target is fetched next.
                stall_if = 1'b1;
                flush_id = 1'b1;
                if (imem_ready) begin
                    state_d = ST_RUN;
                end
            end else if (!load_use && !imem_ready) begin
                stall_if = 1'b1;
                flush_id = 1'b1;
            end
        end
    end

    // Dmem wait counter, timeout flag and stall cycle counter
    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        stall_cnt_d   = stall_cnt_q;

        if (dmem_wait) begin
            wait_cnt_d = (wait_cnt_q == TO_LIMIT) ? wait_cnt_q : (wait_cnt_q + TO_ONE);
        end
        // Flag rises together with the counter reaching the limit, so it is
        // visible in the cycle right after the TIMEOUT-th waiting cycle.
        if (wait_cnt_d == TO_LIMIT) begin
            mem_timeout_d = 1'b1;
        end

        if (stall_if && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    always_comb begin
        mem_timeout = mem_timeout_q;
        stall_cnt   = stall_cnt_q;
    end

endmodule
